// File: rtl/interp_pkg.sv
// Shared types, defaults and helpers for the interpolation upsampler.
package interp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DATA_WIDTH_DEF = 5;

  // Phase counter width: $clog2(L), never narrower than one bit.
  function automatic int unsigned phase_width(input int unsigned l);
    return (l <= 1) ? 1 : $clog2(l);
  endfunction

endpackage

// File: rtl/interp_hold_buf.sv
// One-entry sample buffer; a write in the drain cycle replaces the drained entry.
module interp_hold_buf
  import interp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr,
  input  logic                         rd,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         vld,
  output logic                         ready_c
);

  // Space is available when empty or when the entry leaves this cycle.
  assign ready_c = !vld || rd;

  // Capture on accept, otherwise empty on drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
      vld  <= 1'b0;
    end else if (wr) begin
      dout <= din;
      vld  <= 1'b1;
    end else if (rd) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/interp_upsampler.sv
// Zero-stuffing / zero-order-hold upsampler feeding the interpolation FIR.
module interp_upsampler
  import interp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int unsigned UPSAMPLE_FACTOR = 4,
  parameter int unsigned HOLD_MODE       = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in,
  output logic signed [DATA_WIDTH-1:0] out,
  output logic                         out_valid,
  output logic                         frame_start,
  output logic                         underrun
);

  localparam int unsigned PW = phase_width(UPSAMPLE_FACTOR);
  localparam logic [PW-1:0] LAST = PW'(UPSAMPLE_FACTOR - 1);

  state_t                       state;
  logic [PW-1:0]                phase;
  logic signed [DATA_WIDTH-1:0] hold_q;
  logic                         hold_vld;
  logic                         ready_c;
  logic                         load_c;
  logic                         accept_c;

  assign in_ready = ready_c;
  assign accept_c = in_valid && ready_c;

  interp_hold_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hold_buf (
    .clk    (clk),
    .rst    (rst),
    .wr     (accept_c),
    .rd     (load_c),
    .din    (in),
    .dout   (hold_q),
    .vld    (hold_vld),
    .ready_c(ready_c)
  );

  // Load cycle: start of a frame in IDLE, or the last phase while running.
  always_comb begin
    load_c = 1'b0;
    if (en) begin
      if (state == IDLE) load_c = hold_vld;
      else               load_c = (phase == LAST);
    end
  end

  // Frame FSM, phase counter and registered output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      phase       <= '0;
      out         <= '0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else if (!en) begin
      state       <= IDLE;
      phase       <= '0;
      out         <= '0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          phase <= '0;
          if (hold_vld) begin
            state       <= RUN;
            out         <= hold_q;
            out_valid   <= 1'b1;
            frame_start <= 1'b1;
          end else begin
            out         <= '0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
          end
        end
        RUN: begin
          out_valid <= 1'b1;
          phase     <= (phase == LAST) ? '0 : PW'(phase + 1'b1);
          if (phase == LAST) begin
            frame_start <= 1'b1;
            if (hold_vld) begin
              out <= hold_q;
            end else begin
              out      <= '0;
              underrun <= 1'b1;
            end
          end else begin
            frame_start <= 1'b0;
            out         <= (HOLD_MODE != 0) ? out : '0;
          end
        end
        default: begin
          state <= IDLE;
          phase <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/interp_upsampler.md
Name: interp_upsampler

Overview:
- Zero-stuffing upsampler that sits directly upstream of the transposed-form FIR in the interpolation chain.
- Accepts low-rate signed samples over a valid/ready handshake.
- Emits one high-rate sample every clock: each input sample followed by UPSAMPLE_FACTOR-1 zeros, or repeated copies in hold mode.
- Its output drives the FIR data input directly; the FIR consumes every cycle.

Parameters:
- DATA_WIDTH, 5: signed sample width, input and output.
- UPSAMPLE_FACTOR, 4: interpolation factor L, legal range L >= 1.
- HOLD_MODE, 0: 0 = zero-stuff; 1 = zero-order hold (repeat sample L times).

Ports:
- clk  input  1  system clock, high-rate domain.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  run enable; low forces IDLE synchronously.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- in  input  DATA_WIDTH  signed input sample.
- out  output  DATA_WIDTH  signed high-rate sample, registered, to the FIR.
- out_valid  output  1  high while in RUN.
- frame_start  output  1  high when out carries a new input sample (phase 0).
- underrun  output  1  sticky: a frame started with no sample buffered.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, phase=0, hold buffer empty, out=0, out_valid=0, frame_start=0, underrun=0. in_ready=1 as soon as reset releases.
- Hold buffer: one entry, hold_q/hold_vld. A sample is accepted when in_valid && in_ready, and is written into hold_q at that edge.
- in_ready = !hold_vld || load. "load" is the cycle in which the buffer is drained into out. Accept and drain in the same cycle are legal: the new sample replaces the drained one.
- Phase counter: width $clog2(L), minimum 1 bit. Counts 0..L-1 in RUN and wraps at L-1. Held at 0 in IDLE.
- State IDLE:
  - out=0, out_valid=0.
  - If en && hold_vld: load fires, out<=hold_q, phase<=0, state->RUN, frame_start<=1.
- State RUN:
  - Every edge: phase<=phase+1 with wrap.
  - At phase==L-1 (load cycle), out<=hold_q with frame_start<=1 if hold_vld.
  - If !hold_vld at the load cycle: out<=0, frame_start<=1, underrun<=1. Stay in RUN; the output rate never stalls.
  - Non-load cycles: out<=(HOLD_MODE ? last loaded sample : 0), frame_start<=0.
  - en=0: next edge state->IDLE, phase<=0, out<=0, out_valid<=0, frame_start<=0, underrun<=0. Hold buffer contents are retained.
- L=1: every RUN cycle is a load cycle; the block is a pass-through with one register of latency, and in_ready stays 1 under continuous streaming.
- Latency: a sample accepted at edge k while IDLE with en=1 appears on out after edge k+1.
- Arithmetic: no scaling; out is a bit-exact copy of in or zero. Gain compensation by L is the downstream FIR's job.
- out_valid is the registered RUN indicator, aligned with out.

Decomposition:
- Package interp_pkg:
  - state enum {IDLE, RUN}.
  - phase-width function max(1, $clog2(L)).
  - Shared DATA_WIDTH default constant.
- Sub-module interp_hold_buf: the one-entry buffer with accept/drain and simultaneous replace. All FSM, phase and output logic stays in the top module.

Test Plan:
- Reset: hold rst=0 -> out=0, out_valid=0, underrun=0. Release -> in_ready=1.
- Stream, L=4, HOLD_MODE=0, en=1, samples 3,5,-2 offered continuously -> out = 3,0,0,0,5,0,0,0,-2,0,0,0. frame_start on each nonzero load. in_ready low only while the buffer is full between loads.
- HOLD_MODE=1, same stimulus -> out = 3,3,3,3,5,5,5,5,-2,-2,-2,-2.
- Underrun: single sample 7, then in_valid=0 -> out = 7,0,0,0,0,0,0,0. underrun rises at the edge of the second frame_start and stays 1. out_valid stays 1.
- Disable mid-frame: en=0 at phase 2 with sample 9 buffered -> next edge out=0, out_valid=0, underrun cleared. Re-assert en -> out=9 after one edge.
- Async reset mid-frame: pulse rst low between clock edges -> out, out_valid and underrun clear immediately, with no edge required. L=1 build streaming 1,2,3 -> out=1,2,3 with one-cycle latency.
